product_accumulator: RTL
========================

Name: product_accumulator

Overview:
- Streaming accumulator directly downstream of the 32x32 signed combinational multiplier.
- Consumes signed 64-bit products over a valid/ready handshake and sums TERMS of them, or fewer if a frame is closed early.
- Presents the saturated signed sum on a valid/ready output port.
- Together with the multiplier, forms the dot-product / MAC datapath.

Parameters:
- IN_W, 64: width of the signed input product; must satisfy IN_W <= ACC_W.
- ACC_W, 64: width of the signed accumulator and of out_sum.
- TERMS, 4: maximum number of products per frame; must be >= 1.
- CNT_W, $clog2(TERMS+1): width of out_count (derived; not overridden).

Ports:
- clk, input, 1: single rising-edge clock.
- rst_n, input, 1: synchronous active-low reset.
- clear, input, 1: synchronous frame abort.
- in_valid, input, 1: in_product/in_last are valid.
- in_ready, output, 1: block accepts a product this cycle.
- in_product, input, IN_W: signed product from the multiplier.
- in_last, input, 1: this product closes the frame early.
- out_valid, output, 1: frame result is available.
- out_ready, input, 1: downstream consumes the result.
- out_sum, output, ACC_W: signed accumulated sum.
- out_count, output, CNT_W: number of products summed in this frame.
- out_sat, output, 1: sticky flag; saturation occurred in this frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset:
  - state=ACCUM; acc=0, cnt=0, sat=0.
  - out_valid=0, out_sum=0, out_count=0, out_sat=0.
  - in_ready=0 while rst_n=0.
- States:
  - ACCUM: collecting products.
  - HOLD: result presented, waiting for out_ready.
- in_ready = rst_n && !clear && (state==ACCUM). This is combinational; all other outputs are registered.
- Accept: a beat is accepted when in_valid && in_ready. On the accepting edge:
  - acc <= sat(acc + sext(in_product)).
  - cnt <= cnt+1.
  - sat <= sat | ovf.
- ACCUM -> HOLD on an accepted beat when cnt+1==TERMS or in_last=1. out_valid rises on the same edge, so latency is 1 cycle from the last accepted beat to out_valid.
- in_last on the first beat gives count=1. A frame with zero products is not possible.
- HOLD:
  - in_ready=0; in_valid is ignored with no side effects.
  - out_sum, out_count and out_sat stay stable until the handshake completes.
- HOLD -> ACCUM on out_valid && out_ready:
  - acc, cnt and sat are set to 0; out_valid falls on that edge.
  - There is no same-cycle bypass: the first beat of the next frame is accepted at the earliest on the following cycle.
- Outputs: out_sum=acc, out_count=cnt and out_sat=sat at all times. In ACCUM they show running values while out_valid=0.
- Arithmetic:
  - sext extends IN_W to ACC_W.
  - The sum is computed at ACC_W+1 bits.
  - Positive overflow clamps to 2^(ACC_W-1)-1; negative overflow clamps to -2^(ACC_W-1); either case sets ovf.
  - Later beats add to the clamped value. The result is not pinned at the rail.
- clear:
  - Priority: rst_n > clear > handshakes.
  - Asserting clear in either state sets state=ACCUM, acc=0, cnt=0, sat=0 and out_valid=0.
  - A pending out_valid is dropped; an in_valid beat in the same cycle is not accepted.
- Reset asserted mid-frame or in HOLD: behaves exactly as reset; the partial or held result is discarded.
- cnt never exceeds TERMS; there is no wrap-around.

Test Plan:
- Full frame, TERMS=4: products 30, 28, -40, -250 on consecutive cycles with out_ready=1 -> out_valid=1 one cycle after the 4th beat. out_sum=-232 (0xFFFF_FFFF_FFFF_FF18), out_count=4, out_sat=0; out_valid drops the next cycle.
- Early close: 99, then 736 with in_last=1 -> out_sum=835, out_count=2. A third in_valid beat held high during HOLD is not accepted and becomes the first beat of the next frame.
- Backpressure: complete a frame, then hold out_ready=0 for 3 cycles with in_valid=1 -> out_valid stays 1, outputs are stable and in_ready=0. Raise out_ready -> one transfer, then in_ready=1 on the next cycle.
- Saturation (ACC_W=64):
  - Beats 0x7FFF_FFFF_FFFF_FFFF, 1, -5, in_last on the 3rd -> out_sum=0x7FFF_FFFF_FFFF_FFFA, out_sat=1.
  - Symmetric case with 0x8000_0000_0000_0000 and -1 -> clamps to the minimum.
- clear / reset:
  - Accept 5, then 6, with clear asserted in the same cycle as 6 -> 6 is not taken. Next frame 1,1,1,1 -> out_sum=4, out_count=4.
  - Assert rst_n=0 for 1 cycle during HOLD -> out_valid=0 and all outputs 0 on the next edge.
- Zero operands: four beats of 0 -> out_sum=0, out_count=4, out_sat=0.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Product-in / sum-out streaming bus of the product accumulator.
// The slave modport belongs to the accumulator; the master modport is the side that feeds it products.
interface product_accumulator_if #(
    parameter int IN_W  = 64,
    parameter int ACC_W = 64,
    parameter int TERMS = 4
);
    localparam int CNT_W = $clog2(TERMS + 1);

    // Both ports use strict valid/ready. A beat transfers on a rising clk edge
    // only when valid and ready are both 1. A producer holding valid keeps its
    // payload stable until the transfer. ready may depend combinationally on
    // state, but never on valid.
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_product;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport slave (
        input  in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_sat
    );

    modport master (
        output in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_sat
    );
endinterface

// File: rtl/product_accumulator.sv
// Saturating frame accumulator for signed multiplier products.
// It sums up to TERMS beats per frame and holds the result until the downstream side takes it.
module product_accumulator #(
    parameter int IN_W  = 64,
    parameter int ACC_W = 64,
    parameter int TERMS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    product_accumulator_if.slave bus,
    output logic [0:0]           state_o
);
    localparam int CNT_W = $clog2(TERMS + 1);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             valid_q, valid_d;

    logic             in_ready;
    logic             accept;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum_w;
    logic             ovf;
    logic [ACC_W-1:0] sum_clamped;
    logic [CNT_W-1:0] cnt_inc;

    assign in_ready = rst_n && !clear && (state_q == ST_ACCUM);
    assign accept   = bus.in_valid && in_ready;

    // One guard bit: an overflow shows up as the guard bit disagreeing with the ACC_W-bit sign.
    assign prod_ext    = ACC_W'(signed'(bus.in_product));
    assign sum_w       = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
    assign ovf         = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    assign sum_clamped = ovf ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX) : sum_w[ACC_W-1:0];
    assign cnt_inc     = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        if (clear) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            valid_d = 1'b0;
        end else if (state_q == ST_HOLD) begin
            if (valid_q && bus.out_ready) begin
                state_d = ST_ACCUM;
                acc_d   = '0;
                cnt_d   = '0;
                sat_d   = 1'b0;
                valid_d = 1'b0;
            end
        end else if (accept) begin
            acc_d = sum_clamped;
            cnt_d = cnt_inc;
            sat_d = sat_q | ovf;
            if ((cnt_inc == CNT_W'(TERMS)) || bus.in_last) begin
                state_d = ST_HOLD;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_sum   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_sat   = sat_q;
    assign state_o       = state_q;
endmodule
